// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg
// Shared definitions for the TX packet scheduler:
//   - default datapath widths (interval counter, segment, copy, sequence)
//   - width of the saturating overrun counter
//   - scheduler FSM state encoding
// ---------------------------------------------------------------------------
package tx_sched_pkg;

    localparam int CNT_W = 28;  // interval counter / max_count width
    localparam int SEG_W = 16;  // segment index width
    localparam int RED_W = 8;   // redundancy copy index width
    localparam int SEQ_W = 32;  // burst sequence number width
    localparam int OVR_W = 16;  // overrun counter width (saturating)

    typedef enum logic {
        IDLE = 1'b0,  // waiting for an interval tick
        SEND = 1'b1   // burst in progress, offering requests
    } state_e;

endpackage : tx_sched_pkg

// File: rtl/interval_timer.sv
// ---------------------------------------------------------------------------
// interval_timer
// Free-running interval counter producing a one-cycle tick every
// max_count+1 cycles while enabled.
//
// Ports:
//   clk        in   TX clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   run/stop; when low the counter is held at zero
//   max_count  in   terminal count; period = max_count+1 cycles
//   tick       out  high in the cycle where the counter reaches max_count
// ---------------------------------------------------------------------------
module interval_timer
    import tx_sched_pkg::*;
#(
    parameter int TIMER_W = CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [TIMER_W-1:0] max_count,
    output logic               tick
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // '>=' rather than '==' so that shrinking max_count below the current
    // count wraps on the next cycle instead of running the full counter range.
    always_comb begin
        tick  = enable && (cnt_q >= max_count);
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : interval_timer

// File: rtl/tx_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tx_packet_scheduler
// Turns the decoded rate/burst configuration into a stream of per-packet
// transmit requests. Each interval tick launches a burst of
// max(segment_num_max,1) x max(redundancy,1) requests, offered one at a time
// to the frame builder over a valid/ready handshake. Ticks that arrive while
// a burst is still running are dropped and counted.
//
// Ports:
//   clk, rst_n        TX clock (125 MHz), asynchronous active-low reset
//   enable            run/stop for the interval timer
//   max_count         interval terminal value (period = max_count+1 cycles)
//   segment_num_max   segments per burst (0 treated as 1)
//   redundancy        copies per segment (0 treated as 1)
//   pkt_valid/ready   request handshake towards the frame builder
//   pkt_seq           burst sequence number (same for all beats of a burst)
//   pkt_segment       segment index within burst, 0-based
//   pkt_copy          copy index within segment, 0-based
//   pkt_last          final request of the burst
//   busy              burst in progress
//   overrun_cnt       ticks dropped during a burst, saturating
// ---------------------------------------------------------------------------
module tx_packet_scheduler #(
    parameter int CNT_W = tx_sched_pkg::CNT_W,
    parameter int SEG_W = tx_sched_pkg::SEG_W,
    parameter int RED_W = tx_sched_pkg::RED_W,
    parameter int SEQ_W = tx_sched_pkg::SEQ_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] max_count,
    input  logic [SEG_W-1:0] segment_num_max,
    input  logic [RED_W-1:0] redundancy,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic [SEQ_W-1:0] pkt_seq,
    output logic [SEG_W-1:0] pkt_segment,
    output logic [RED_W-1:0] pkt_copy,
    output logic             pkt_last,
    output logic             busy,
    output logic [15:0]      overrun_cnt
);

    import tx_sched_pkg::*;

    state_e           state_q, state_d;
    logic             tick;
    logic             handshake;
    logic             last_beat;

    // Burst shape latched at burst start; later input changes are ignored
    // until the scheduler is back in IDLE.
    logic [SEG_W-1:0] seg_max_q, seg_max_d;
    logic [RED_W-1:0] red_q,     red_d;
    logic [SEG_W-1:0] seg_idx_q, seg_idx_d;
    logic [RED_W-1:0] copy_q,    copy_d;
    logic [SEQ_W-1:0] seq_q,     seq_d;
    logic [OVR_W-1:0] ovr_q,     ovr_d;

    interval_timer #(
        .TIMER_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .max_count (max_count),
        .tick      (tick)
    );

    // pkt_ready only qualifies the handshake; it never feeds pkt_valid.
    // last_beat is gated with SEND so it reads 0 while idle.
    assign handshake = (state_q == SEND) && pkt_ready;
    assign last_beat = (state_q == SEND)
                    && (seg_idx_q == seg_max_q - SEG_W'(1))
                    && (copy_q    == red_q     - RED_W'(1));

    // -------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (tick)                   state_d = SEND;
            SEND: if (handshake && last_beat) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // FSM: outputs (all derived from registered state)
    // -------------------------------------------------------------------
    always_comb begin
        pkt_valid   = (state_q == SEND);
        busy        = (state_q == SEND);
        pkt_last    = last_beat;
        pkt_seq     = seq_q;
        pkt_segment = seg_idx_q;
        pkt_copy    = copy_q;
        overrun_cnt = ovr_q;
    end

    // -------------------------------------------------------------------
    // Burst datapath: latched shape, beat indices, sequence, overrun
    // -------------------------------------------------------------------
    always_comb begin
        seg_max_d = seg_max_q;
        red_d     = red_q;
        seg_idx_d = seg_idx_q;
        copy_d    = copy_q;
        seq_d     = seq_q;
        ovr_d     = ovr_q;

        if (state_q == IDLE && tick) begin
            seg_max_d = (segment_num_max == '0) ? SEG_W'(1) : segment_num_max;
            red_d     = (redundancy == '0)      ? RED_W'(1) : redundancy;
            seg_idx_d = '0;
            copy_d    = '0;
        end

        // Copies of a segment go out back-to-back before the next segment.
        // The final beat returns the indices to 0 so idle outputs match reset.
        if (handshake) begin
            if (last_beat) begin
                seg_idx_d = '0;
                copy_d    = '0;
                seq_d     = seq_q + SEQ_W'(1);
            end else if (copy_q < red_q - RED_W'(1)) begin
                copy_d    = copy_q + RED_W'(1);
            end else begin
                copy_d    = '0;
                seg_idx_d = seg_idx_q + SEG_W'(1);
            end
        end

        // A tick in SEND, including one coinciding with the final beat, is
        // dropped rather than queued.
        if (state_q == SEND && tick && ovr_q != '1) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_max_q <= SEG_W'(1);
            red_q     <= RED_W'(1);
            seg_idx_q <= '0;
            copy_q    <= '0;
            seq_q     <= '0;
            ovr_q     <= '0;
        end else begin
            seg_max_q <= seg_max_d;
            red_q     <= red_d;
            seg_idx_q <= seg_idx_d;
            copy_q    <= copy_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule : tx_packet_scheduler

// File: tb/tb_tx_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_packet_scheduler
// Self-checking bench: a cycle-by-cycle vector table for a short
// tick/stall/overrun scenario, plus directed burst sequences covering
// periodic single-beat bursts, multi-segment ordering, ready stalls,
// overrun counting, zero configuration, mid-burst input changes, enable
// drop and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_tx_packet_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [27:0] max_count = '0;
    logic [15:0] segment_num_max = '0;
    logic [7:0]  redundancy = '0;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic [31:0] pkt_seq;
    logic [15:0] pkt_segment;
    logic [7:0]  pkt_copy;
    logic        pkt_last;
    logic        busy;
    logic [15:0] overrun_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    tx_packet_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .max_count       (max_count),
        .segment_num_max (segment_num_max),
        .redundancy      (redundancy),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .pkt_seq         (pkt_seq),
        .pkt_segment     (pkt_segment),
        .pkt_copy        (pkt_copy),
        .pkt_last        (pkt_last),
        .busy            (busy),
        .overrun_cnt     (overrun_cnt)
    );

    always #4 clk = ~clk;  // 125 MHz

    // One row per clock edge: ready driven before the edge, outputs expected
    // just after it. Segment/copy are only compared while valid is expected.
    typedef struct {
        logic        ready;
        logic        v;
        logic [15:0] s;
        logic [7:0]  c;
        logic        l;
        logic [31:0] q;
        logic        b;
        logic [15:0] o;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mkv(input logic r, input logic v, input int s, input int c,
                                 input logic l, input int q, input logic b, input int o);
        vec_t t;
        t.ready = r;
        t.v     = v;
        t.s     = 16'(s);
        t.c     = 8'(c);
        t.l     = l;
        t.q     = 32'(q);
        t.b     = b;
        t.o     = 16'(o);
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across one edge, then releases it with the new config and
    // enable high; the next edge is edge 1 of the timer.
    task automatic do_reset(input int mc, input int seg, input int red);
        rst_n     = 1'b0;
        enable    = 1'b0;
        pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        max_count       = 28'(mc);
        segment_num_max = 16'(seg);
        redundancy      = 8'(red);
        rst_n           = 1'b1;
        enable          = 1'b1;
    endtask

    // Waits (bounded) for a burst, then follows it beat by beat against an
    // independent index model. Optionally changes segment_num_max after
    // chg_at accepted beats to show the latched shape is unaffected.
    task automatic run_burst(input string name, input int segs, input int reds,
                             input bit toggle, input int seq_e,
                             input int chg_at, input int chg_val);
        int  s, c, beats, cyc, ph, waited;
        logic last_e, hs;
        waited = 0;
        while (!pkt_valid && waited < 500) begin
            step();
            waited++;
        end
        check({name, " start"}, pkt_valid, 1'b1);
        if (!pkt_valid) return;
        s = 0; c = 0; beats = 0; cyc = 0; ph = 0;
        while (beats < segs * reds && cyc < 2000) begin
            last_e = (s == segs - 1) && (c == reds - 1);
            check($sformatf("%s beat%0d", name, beats),
                  {pkt_valid, busy, pkt_segment, pkt_copy, pkt_last, pkt_seq},
                  {1'b1, 1'b1, 16'(s), 8'(c), last_e, 32'(seq_e)});
            pkt_ready = toggle ? (ph % 3 == 0) : 1'b1;
            ph++;
            hs = pkt_valid && pkt_ready;
            step();
            cyc++;
            if (hs) begin
                beats++;
                if (beats == chg_at) segment_num_max = 16'(chg_val);
                if (c < reds - 1) begin
                    c++;
                end else begin
                    c = 0;
                    s++;
                end
            end
        end
        check({name, " beats"}, beats, segs * reds);
        if (!toggle) check({name, " cycles"}, cyc, segs * reds);
        check({name, " after"}, {pkt_valid, busy, pkt_seq}, {1'b0, 1'b0, 32'(seq_e + 1)});
        pkt_ready = 1'b1;
    endtask

    initial begin
        int nv, waited;

        // Reset state (asynchronous, before any clock edge).
        #1;
        check("reset", {pkt_valid, busy, pkt_seq, pkt_segment, pkt_copy, pkt_last, overrun_cnt},
              128'd0);

        // ---- Table: max_count=3, 1 segment x 2 copies, ready stalls, overrun ----
        tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(1, 1, 0, 0, 0, 0, 1, 0);  // tick seen at edge 4
        tbl[4]  = mkv(0, 1, 0, 0, 0, 0, 1, 0);  // stalled
        tbl[5]  = mkv(1, 1, 0, 1, 1, 0, 1, 0);
        tbl[6]  = mkv(0, 1, 0, 1, 1, 0, 1, 0);  // stalled on last beat
        tbl[7]  = mkv(1, 0, 0, 0, 0, 1, 0, 1);  // final beat with tick -> overrun
        tbl[8]  = mkv(1, 0, 0, 0, 0, 1, 0, 1);
        tbl[9]  = mkv(1, 0, 0, 0, 0, 1, 0, 1);
        tbl[10] = mkv(1, 0, 0, 0, 0, 1, 0, 1);
        tbl[11] = mkv(1, 1, 0, 0, 0, 1, 1, 1);
        tbl[12] = mkv(1, 1, 0, 1, 1, 1, 1, 1);
        tbl[13] = mkv(1, 0, 0, 0, 0, 2, 0, 1);

        do_reset(3, 1, 2);
        for (int i = 0; i < 14; i++) begin
            pkt_ready = tbl[i].ready;
            step();
            check($sformatf("tbl edge%0d", i + 1),
                  {pkt_valid, tbl[i].v ? pkt_segment : 16'd0, tbl[i].v ? pkt_copy : 8'd0,
                   pkt_last, pkt_seq, busy, overrun_cnt},
                  {tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].l, tbl[i].q, tbl[i].b, tbl[i].o});
        end

        // ---- Periodic single-beat bursts: max_count=9 -> valid in cycles 10,20,30 ----
        do_reset(9, 1, 1);
        for (int c = 1; c <= 35; c++) begin
            step();
            check($sformatf("period cyc%0d", c), {pkt_valid, pkt_seq},
                  {(c % 10 == 0), 32'((c - 1) / 10)});
        end

        // ---- 2 segments x 3 copies, ready high then ready 1-of-3 ----
        do_reset(99, 2, 3);
        run_burst("b23", 2, 3, 1'b0, 0, 0, 0);
        run_burst("b23_stall", 2, 3, 1'b1, 1, 0, 0);

        // ---- 5 x 7 burst with max_count=3: 8 ticks dropped mid-burst ----
        do_reset(3, 5, 7);
        run_burst("ovr", 5, 7, 1'b0, 0, 0, 0);
        check("ovr count", overrun_cnt, 16'd8);
        step();
        check("ovr next burst", {pkt_valid, pkt_seq}, {1'b1, 32'd1});

        // ---- Asynchronous reset mid-burst ----
        step();
        #1 rst_n = 1'b0;
        #1;
        check("async reset", {pkt_valid, busy, pkt_seq, pkt_segment, pkt_copy, pkt_last,
                              overrun_cnt}, 128'd0);
        do_reset(5, 2, 2);
        run_burst("post_rst", 2, 2, 1'b0, 0, 0, 0);

        // ---- Zero config treated as 1 x 1 ----
        do_reset(3, 0, 0);
        run_burst("zero", 1, 1, 1'b0, 0, 0, 0);

        // ---- segment_num_max 1 -> 5 mid-burst affects only the next burst ----
        do_reset(60, 1, 3);
        run_burst("midchg", 1, 3, 1'b0, 0, 1, 5);
        run_burst("next5", 5, 3, 1'b0, 1, 0, 0);

        // ---- enable dropped mid-burst: burst completes, no further bursts ----
        do_reset(20, 2, 2);
        waited = 0;
        while (!pkt_valid && waited < 100) begin
            step();
            waited++;
        end
        enable = 1'b0;
        run_burst("en_off", 2, 2, 1'b0, 0, 0, 0);
        nv = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (pkt_valid) nv++;
        end
        check("en_off quiet", nv, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tx_packet_scheduler

// File: doc/tx_packet_scheduler.md
# tx_packet_scheduler

Sequences the Ethernet transmit datapath: converts the decoded rate and burst configuration (packet interval, segments per burst, redundancy copies) into a stream of per-packet transmit requests. An interval timer fires once per configured period; each firing launches a burst of `segment_num_max × redundancy` packet requests to the frame builder over a valid/ready handshake. Sits between the switch-decode logic and the TX frame builder/MAC, in the 125 MHz TX clock domain.

## Interface
- `CNT_W`, 28, interval counter / `max_count` width
- `SEG_W`, 16, segment index width
- `RED_W`, 8, redundancy copy width
- `SEQ_W`, 32, burst sequence number width
- `clk`  in  1  TX clock, 125 MHz; the single clock of the block
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run/stop for the interval timer
- `max_count`  in  CNT_W  interval terminal value; period = max_count+1 cycles
- `segment_num_max`  in  SEG_W  segments per burst (0 treated as 1)
- `redundancy`  in  RED_W  copies per segment (0 treated as 1)
- `pkt_valid`  out  1  request to transmit one packet
- `pkt_ready`  in  1  frame builder accepts request
- `pkt_seq`  out  SEQ_W  burst sequence number
- `pkt_segment`  out  SEG_W  segment index within burst, 0-based
- `pkt_copy`  out  RED_W  copy index within segment, 0-based
- `pkt_last`  out  1  final request of the burst
- `busy`  out  1  burst in progress (state SEND)
- `overrun_cnt`  out  16  ticks dropped because a burst was still running

## Operation
- Timer: `cnt` resets to 0; while `enable`=1, `tick`=1 when `cnt >= max_count`, then `cnt`←0, else `cnt`←`cnt`+1. `>=` gives a clean wrap when `max_count` shrinks below `cnt`. `enable`=0: `cnt`←0, no ticks.
- FSM states IDLE, SEND.
- IDLE: on `tick`, latch `seg_max`=max(`segment_num_max`,1), `red`=max(`redundancy`,1); clear segment/copy indices; → SEND.
- SEND: `pkt_valid`=1. On `pkt_valid & pkt_ready`: if `copy`<`red`-1, `copy`++; else `copy`←0, `segment`++. On the handshake where `pkt_last`=1: `pkt_seq`++ (wraps mod 2^SEQ_W), → IDLE.
- `pkt_last` = (`segment`==`seg_max`-1) & (`copy`==`red`-1), combinational from registered state.
- `tick` in SEND: dropped; `overrun_cnt`++, saturating at 0xFFFF. `tick` in the same cycle as the final handshake counts as overrun (not queued).
- Input changes mid-burst have no effect; latched values hold until IDLE.
- `enable` falling mid-burst: current burst completes; no further ticks.
- Reset mid-burst: abort immediately, all state to reset values.

## Timing
- Reset values: `pkt_valid`=0, `busy`=0, `pkt_seq`=0, `pkt_segment`=0, `pkt_copy`=0, `pkt_last`=0, `overrun_cnt`=0, `cnt`=0.
- With `enable` high from cycle 0, ticks occur in cycles max_count, 2·max_count+1, … (every max_count+1 cycles).
- Tick-to-`pkt_valid` latency: 1 cycle (registered FSM).
- Handshake: once asserted, `pkt_valid` and all `pkt_*` fields are stable until accepted; `pkt_ready` may toggle freely and never combinationally affects `pkt_valid`.
- `pkt_ready` held high: one request per cycle; burst occupies exactly `seg_max×red` cycles; `pkt_valid` low in the cycle after the last handshake.
- `pkt_seq` increments on the cycle after the final handshake; all requests of one burst carry the same `pkt_seq`.

## Structure
- Package `tx_sched_pkg`: width constants (CNT_W, SEG_W, RED_W, SEQ_W), state enum {IDLE, SEND}, overrun counter width.
- Sub-module `interval_timer`: counter plus `tick` generation (`clk`, `rst_n`, `enable`, `max_count` → `tick`). FSM, index counters, and handshake live in the top.

## Test plan
- max_count=9, seg=1, red=1, ready=1 → `pkt_valid` pulses 1 cycle every 10 cycles, first request in cycle 10, `pkt_seq` 0,1,2…
- max_count=99, seg=2, red=3, ready=1 → 6 consecutive beats (seg,copy) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), `pkt_last` only on the 6th.
- Same config, `pkt_ready` toggling 1-of-3 cycles → fields stable while stalled, same 6-beat order, no lost/duplicated beats.
- max_count=3, seg=5, red=7, ready=1 → 35-cycle burst overlaps ticks; `overrun_cnt` increments per dropped tick, next burst starts only after a tick seen in IDLE.
- segment_num_max=0, redundancy=0 → single beat per tick with `pkt_last`=1; change segment_num_max 1→5 mid-burst → current burst unchanged, next burst 5 segments.
- `rst_n` low mid-burst → all outputs return to reset values asynchronously; after release and enable, `pkt_seq` restarts at 0.
